// File: rtl/control_registers.sv
// control_registers
//
// Memory-mapped bank of WORD_COUNT 32-bit control registers. The processor
// writes and reads the registers over the data-memory request bus. The
// peripheral reads them continuously and may overwrite any word itself.
//
// Ports:
//   clk, aresetn             clock, asynchronous active-low reset
//   i_req_addr               byte address of the processor request
//   i_req_count              access size (NONE / BYTE / HALF / WORD)
//   i_req_wr_en              1 = write, 0 = read
//   i_req_wr_data            right-aligned write data
//   o_res_rd_data            registered readback data, zero-extended
//   o_res_code               registered response code
//   o_registers              current contents, word i at [(i+1)*32-1 : i*32]
//   o_written                one-cycle pulse per word after a processor write
//   i_hw_wr_en               per-word peripheral overwrite strobe
//   i_hw_wr_data             peripheral overwrite data, same packing as o_registers

`ifndef CONTROL_REGISTERS_DEFS
`define CONTROL_REGISTERS_DEFS
`define WORD_W 32
`define ADDR_W 32
`define MEM_COUNT_W 3
`define MEM_COUNT_NONE 3'd0
`define MEM_COUNT_BYTE 3'd1
`define MEM_COUNT_HALF 3'd2
`define MEM_COUNT_WORD 3'd3
`define MEM_CODE_W 3
`define MEM_CODE_INVALID 3'd0
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`endif

module control_registers #(
   parameter int WORD_COUNT = 1,
   parameter logic [`ADDR_W-1:0] ADDR_START = '0,
   parameter logic [WORD_COUNT*`WORD_W-1:0] RESET_VALUE = '0
) (
   input  logic                          clk,
   input  logic                          aresetn,
   input  logic [`ADDR_W-1:0]            i_req_addr,
   input  logic [`MEM_COUNT_W-1:0]       i_req_count,
   input  logic                          i_req_wr_en,
   input  logic [`WORD_W-1:0]            i_req_wr_data,
   output logic [`WORD_W-1:0]            o_res_rd_data,
   output logic [`MEM_CODE_W-1:0]        o_res_code,
   output logic [WORD_COUNT*`WORD_W-1:0] o_registers,
   output logic [WORD_COUNT-1:0]         o_written,
   input  logic [WORD_COUNT-1:0]         i_hw_wr_en,
   input  logic [WORD_COUNT*`WORD_W-1:0] i_hw_wr_data
);

   logic [`WORD_W-1:0]     regs [WORD_COUNT];
   logic [`ADDR_W-1:0]     rel_addr;
   logic [`ADDR_W-1:0]     word_idx;
   logic [1:0]             offset;
   logic                   misaligned;
   logic                   out_of_range;
   logic                   count_known;
   logic [`WORD_W-1:0]     cur_word;
   logic [`WORD_W-1:0]     merged_word;
   logic [`WORD_W-1:0]     rd_next;
   logic [`MEM_CODE_W-1:0] code_next;
   logic                   proc_wr;

   // Address decode. A request below ADDR_START wraps rel_addr, so the
   // explicit lower-bound compare is what rejects it.
   always_comb begin
      rel_addr     = i_req_addr - ADDR_START;
      word_idx     = rel_addr >> 2;
      offset       = i_req_addr[1:0];
      misaligned   = ((i_req_count == `MEM_COUNT_HALF) && offset[0]) ||
                     ((i_req_count == `MEM_COUNT_WORD) && (offset != 2'd0));
      out_of_range = (i_req_addr < ADDR_START) ||
                     (word_idx >= `ADDR_W'(WORD_COUNT));
      count_known  = (i_req_count == `MEM_COUNT_BYTE) ||
                     (i_req_count == `MEM_COUNT_HALF) ||
                     (i_req_count == `MEM_COUNT_WORD);
   end

   // Select the addressed word (pre-edge contents) and build the merged
   // value a processor write would store, keeping untouched lanes.
   always_comb begin
      cur_word = '0;
      for (int i = 0; i < WORD_COUNT; i++) begin
         if (word_idx == `ADDR_W'(i)) begin
            cur_word = regs[i];
         end
      end
      merged_word = cur_word;
      case (i_req_count)
         `MEM_COUNT_BYTE: begin
            case (offset)
               2'd0:    merged_word[7:0]   = i_req_wr_data[7:0];
               2'd1:    merged_word[15:8]  = i_req_wr_data[7:0];
               2'd2:    merged_word[23:16] = i_req_wr_data[7:0];
               default: merged_word[31:24] = i_req_wr_data[7:0];
            endcase
         end
         `MEM_COUNT_HALF: begin
            if (offset[1]) begin
               merged_word[31:16] = i_req_wr_data[15:0];
            end else begin
               merged_word[15:0] = i_req_wr_data[15:0];
            end
         end
         `MEM_COUNT_WORD: merged_word = i_req_wr_data;
         default:         merged_word = cur_word;
      endcase
   end

   // Response selection in priority order: no request, misalignment,
   // out-of-range address, unknown size, then the actual read or write.
   always_comb begin
      rd_next   = '0;
      code_next = `MEM_CODE_INVALID;
      proc_wr   = 1'b0;
      if (i_req_count == `MEM_COUNT_NONE) begin
         code_next = `MEM_CODE_INVALID;
      end else if (misaligned) begin
         code_next = `MEM_CODE_MISALIGNED;
      end else if (out_of_range || !count_known) begin
         code_next = `MEM_CODE_INVALID;
      end else if (i_req_wr_en) begin
         code_next = `MEM_CODE_WRITE;
         proc_wr   = 1'b1;
      end else begin
         code_next = `MEM_CODE_READ;
         case (i_req_count)
            `MEM_COUNT_BYTE: begin
               case (offset)
                  2'd0:    rd_next = {24'd0, cur_word[7:0]};
                  2'd1:    rd_next = {24'd0, cur_word[15:8]};
                  2'd2:    rd_next = {24'd0, cur_word[23:16]};
                  default: rd_next = {24'd0, cur_word[31:24]};
               endcase
            end
            `MEM_COUNT_HALF: begin
               rd_next = offset[1] ? {16'd0, cur_word[31:16]}
                                   : {16'd0, cur_word[15:0]};
            end
            default: rd_next = cur_word;
         endcase
      end
   end

   // Registered response.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         o_res_rd_data <= '0;
         o_res_code    <= `MEM_CODE_INVALID;
      end else begin
         o_res_rd_data <= rd_next;
         o_res_code    <= code_next;
      end
   end

   // Register storage. A processor write to a word takes all 32 bits even
   // when the peripheral strobes the same word on the same edge.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < WORD_COUNT; i++) begin
            regs[i]      <= RESET_VALUE[i*`WORD_W +: `WORD_W];
            o_written[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < WORD_COUNT; i++) begin
            if (proc_wr && (word_idx == `ADDR_W'(i))) begin
               regs[i]      <= merged_word;
               o_written[i] <= 1'b1;
            end else begin
               o_written[i] <= 1'b0;
               if (i_hw_wr_en[i]) begin
                  regs[i] <= i_hw_wr_data[i*`WORD_W +: `WORD_W];
               end
            end
         end
      end
   end

   // Flatten the register array onto the peripheral-facing bus.
   always_comb begin
      o_registers = '0;
      for (int i = 0; i < WORD_COUNT; i++) begin
         o_registers[i*`WORD_W +: `WORD_W] = regs[i];
      end
   end

endmodule

// File: tb/tb_control_registers.sv
`ifndef CONTROL_REGISTERS_DEFS
`define CONTROL_REGISTERS_DEFS
`define WORD_W 32
`define ADDR_W 32
`define MEM_COUNT_W 3
`define MEM_COUNT_NONE 3'd0
`define MEM_COUNT_BYTE 3'd1
`define MEM_COUNT_HALF 3'd2
`define MEM_COUNT_WORD 3'd3
`define MEM_CODE_W 3
`define MEM_CODE_INVALID 3'd0
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`endif

module tb_control_registers;

   localparam int          WC    = 2;
   localparam logic [31:0] START = 32'h0000_0100;
   localparam logic [63:0] RST   = {32'h0000_0000, 32'h0000_00A5};

   localparam logic [2:0] CN = `MEM_COUNT_NONE;
   localparam logic [2:0] CB = `MEM_COUNT_BYTE;
   localparam logic [2:0] CH = `MEM_COUNT_HALF;
   localparam logic [2:0] CW = `MEM_COUNT_WORD;
   localparam logic [2:0] RI = `MEM_CODE_INVALID;
   localparam logic [2:0] RR = `MEM_CODE_READ;
   localparam logic [2:0] RW = `MEM_CODE_WRITE;
   localparam logic [2:0] RM = `MEM_CODE_MISALIGNED;

   logic        clk;
   logic        aresetn;
   logic [31:0] req_addr;
   logic [2:0]  req_count;
   logic        req_wr_en;
   logic [31:0] req_wr_data;
   logic [31:0] res_rd_data;
   logic [2:0]  res_code;
   logic [63:0] registers;
   logic [1:0]  written;
   logic [1:0]  hw_wr_en;
   logic [63:0] hw_wr_data;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [2:0]  count;
      logic        wr_en;
      logic [31:0] wr_data;
      logic [1:0]  hw_en;
      logic [63:0] hw_data;
      logic [31:0] exp_rd;
      logic [2:0]  exp_code;
      logic [63:0] exp_regs;
      logic [1:0]  exp_written;
   } vec_t;

   vec_t vecs[$];

   control_registers #(
      .WORD_COUNT (WC),
      .ADDR_START (START),
      .RESET_VALUE(RST)
   ) dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .i_req_addr   (req_addr),
      .i_req_count  (req_count),
      .i_req_wr_en  (req_wr_en),
      .i_req_wr_data(req_wr_data),
      .o_res_rd_data(res_rd_data),
      .o_res_code   (res_code),
      .o_registers  (registers),
      .o_written    (written),
      .i_hw_wr_en   (hw_wr_en),
      .i_hw_wr_data (hw_wr_data)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic addVec(input string name, input logic [31:0] addr, input logic [2:0] count,
                         input logic wr_en, input logic [31:0] wr_data, input logic [1:0] hw_en,
                         input logic [63:0] hw_data, input logic [31:0] exp_rd,
                         input logic [2:0] exp_code, input logic [63:0] exp_regs,
                         input logic [1:0] exp_written);
      vec_t v;
      v.name = name; v.addr = addr; v.count = count; v.wr_en = wr_en; v.wr_data = wr_data;
      v.hw_en = hw_en; v.hw_data = hw_data; v.exp_rd = exp_rd; v.exp_code = exp_code;
      v.exp_regs = exp_regs; v.exp_written = exp_written;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] count, input logic wr_en,
                                input logic [31:0] wr_data, input logic [1:0] hw_en,
                                input logic [63:0] hw_data);
      req_addr    = addr;
      req_count   = count;
      req_wr_en   = wr_en;
      req_wr_data = wr_data;
      hw_wr_en    = hw_en;
      hw_wr_data  = hw_data;
   endtask

   task automatic checkAll(input string name, input logic [31:0] rd, input logic [2:0] code,
                           input logic [63:0] regs, input logic [1:0] wr);
      checkOutput({name, ".rd"}, {32'd0, res_rd_data}, {32'd0, rd});
      checkOutput({name, ".code"}, {61'd0, res_code}, {61'd0, code});
      checkOutput({name, ".regs"}, registers, regs);
      checkOutput({name, ".written"}, {62'd0, written}, {62'd0, wr});
   endtask

   initial begin
      addVec("rd_w0",       32'h100, CW, 1'b0, 32'h0,        2'b00, 64'h0,
             32'h0000_00A5, RR, {32'h0, 32'hA5}, 2'b00);
      addVec("wr_w1",       32'h104, CW, 1'b1, 32'hDEADBEEF, 2'b00, 64'h0,
             32'h0, RW, {32'hDEADBEEF, 32'hA5}, 2'b10);
      addVec("wrb_w1",      32'h106, CB, 1'b1, 32'hFFFF_FF11, 2'b00, 64'h0,
             32'h0, RW, {32'hDE11BEEF, 32'hA5}, 2'b10);
      addVec("rd_w1",       32'h104, CW, 1'b0, 32'h0,        2'b00, 64'h0,
             32'hDE11BEEF, RR, {32'hDE11BEEF, 32'hA5}, 2'b00);
      addVec("rdb_w1",      32'h105, CB, 1'b0, 32'h0,        2'b00, 64'h0,
             32'h0000_00BE, RR, {32'hDE11BEEF, 32'hA5}, 2'b00);
      addVec("rdh_w1",      32'h106, CH, 1'b0, 32'h0,        2'b00, 64'h0,
             32'h0000_DE11, RR, {32'hDE11BEEF, 32'hA5}, 2'b00);
      addVec("misal_rdh",   32'h101, CH, 1'b0, 32'h0,        2'b00, 64'h0,
             32'h0, RM, {32'hDE11BEEF, 32'hA5}, 2'b00);
      addVec("misal_wrw",   32'h106, CW, 1'b1, 32'h12345678, 2'b00, 64'h0,
             32'h0, RM, {32'hDE11BEEF, 32'hA5}, 2'b00);
      addVec("oor_high",    32'h108, CW, 1'b1, 32'h12345678, 2'b00, 64'h0,
             32'h0, RI, {32'hDE11BEEF, 32'hA5}, 2'b00);
      addVec("oor_low",     32'h0FC, CW, 1'b1, 32'h12345678, 2'b00, 64'h0,
             32'h0, RI, {32'hDE11BEEF, 32'hA5}, 2'b00);
      addVec("count_none",  32'h100, CN, 1'b1, 32'h12345678, 2'b00, 64'h0,
             32'h0, RI, {32'hDE11BEEF, 32'hA5}, 2'b00);
      addVec("count_bad",   32'h100, 3'd5, 1'b1, 32'hFFFFFFFF, 2'b00, 64'h0,
             32'h0, RI, {32'hDE11BEEF, 32'hA5}, 2'b00);
      addVec("wr_w0_ones",  32'h100, CW, 1'b1, 32'hFFFFFFFF, 2'b00, 64'h0,
             32'h0, RW, {32'hDE11BEEF, 32'hFFFFFFFF}, 2'b01);
      addVec("proc_vs_hw",  32'h100, CH, 1'b1, 32'h0000_1234, 2'b01, 64'h0,
             32'h0, RW, {32'hDE11BEEF, 32'hFFFF1234}, 2'b01);
      addVec("hw_only",     32'h100, CN, 1'b0, 32'h0,        2'b01, 64'h0,
             32'h0, RI, {32'hDE11BEEF, 32'h0}, 2'b00);
      addVec("rd_during_hw",32'h104, CW, 1'b0, 32'h0,        2'b10, {32'hCAFEF00D, 32'h0},
             32'hDE11BEEF, RR, {32'hCAFEF00D, 32'h0}, 2'b00);
      addVec("b2b_wr",      32'h100, CB, 1'b1, 32'h0000_00AB, 2'b00, 64'h0,
             32'h0, RW, {32'hCAFEF00D, 32'hAB}, 2'b01);
      addVec("b2b_rd",      32'h100, CH, 1'b0, 32'h0,        2'b00, 64'h0,
             32'h0000_00AB, RR, {32'hCAFEF00D, 32'hAB}, 2'b00);
      addVec("wrh_hi",      32'h102, CH, 1'b1, 32'h0000_5566, 2'b00, 64'h0,
             32'h0, RW, {32'hCAFEF00D, 32'h556600AB}, 2'b01);
      addVec("rdb_lane3",   32'h103, CB, 1'b0, 32'h0,        2'b00, 64'h0,
             32'h0000_0055, RR, {32'hCAFEF00D, 32'h556600AB}, 2'b00);
      addVec("hw_parallel", 32'h104, CW, 1'b1, 32'h01020304, 2'b11, {32'hFFFFFFFF, 32'h12345678},
             32'h0, RW, {32'h01020304, 32'h12345678}, 2'b10);

      // Reset and check the initial state.
      aresetn = 1'b0;
      applyStimulus(32'h0, CN, 1'b0, 32'h0, 2'b00, 64'h0);
      repeat (2) @(negedge clk);
      checkAll("reset", 32'h0, RI, RST, 2'b00);
      aresetn = 1'b1;

      // Table-driven single-cycle vectors.
      foreach (vecs[k]) begin
         @(negedge clk);
         applyStimulus(vecs[k].addr, vecs[k].count, vecs[k].wr_en, vecs[k].wr_data,
                       vecs[k].hw_en, vecs[k].hw_data);
         @(posedge clk);
         #1;
         checkAll(vecs[k].name, vecs[k].exp_rd, vecs[k].exp_code, vecs[k].exp_regs,
                  vecs[k].exp_written);
      end

      // Reset pulse landing between a write edge and the next edge.
      @(negedge clk);
      applyStimulus(32'h104, CW, 1'b1, 32'h1111_1111, 2'b00, 64'h0);
      @(posedge clk);
      #2;
      aresetn = 1'b0;
      #1;
      checkAll("midreset", 32'h0, RI, RST, 2'b00);
      @(negedge clk);
      aresetn = 1'b1;
      applyStimulus(32'h0, CN, 1'b0, 32'h0, 2'b00, 64'h0);
      @(posedge clk);
      #1;
      checkAll("post_reset", 32'h0, RI, RST, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
